mode_sequencer: RTL and testbench

- Upstream stage that produces the SELECTOR operation mode (opr_mode_t) for the select_action datapath from raw board push-buttons.
- Each raw button is synchronised, debounced and edge-detected.
- UP/DOWN step through the operation modes with wrap-around; CENTER forces RESET mode.
- Also emits a one-cycle mode_changed strobe and a SW snapshot register (operand capture), so downstream logic sees operands that are stable across a mode step.

---
 rtl/mode_sequencer.sv | 78 +++++++
 tb/tb_mode_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// mode_sequencer: debounced push-button stepping of the SELECTOR operation mode with switch snapshot
module mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2,
  parameter int WIDTH           = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             BTNU,
  input  logic             BTND,
  input  logic             BTNC,
  input  logic [WIDTH-1:0] SW,
  output logic [2:0]       SELECTOR,
  output logic [WIDTH-1:0] SW_Q,
  output logic             mode_changed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [2:0] {RESET = 3'd0, ADD, SUB, MUL, LEADING_ONES, COUNT_ONES} opr_mode_t;
  logic [2:0] raw, press;
  assign raw = {BTNC, BTND, BTNU};
  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d, prev_q, press_q;
    logic                   diff, done;
    assign diff = sync_q[SYNC_STAGES-1] != lvl_q;
    assign done = cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    // debouncer: count consecutive disagreeing samples, flip the level once enough have been seen
    always_comb begin
      cnt_d = (diff && !done) ? cnt_q + 1'b1 : '0;
      lvl_d = (diff && done) ? ~lvl_q : lvl_q;
    end
    // synchroniser chain, debounce state and registered rising-edge press pulse
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_q  <= '0;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        prev_q  <= 1'b0;
        press_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], raw[b]};
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        prev_q  <= lvl_q;
        press_q <= lvl_q & ~prev_q;
      end
    end
    assign press[b] = press_q;
  end
  opr_mode_t        sel_q, sel_d;
  logic [WIDTH-1:0] sw_q, sw_d;
  logic             chg_q;
  // mode ring stepping: centre overrides, up+down cancel, illegal encodings fall back to RESET
  always_comb begin
    sel_d = sel_q;
    if (sel_q > COUNT_ONES) sel_d = RESET;
    else if (press[2]) sel_d = RESET;
    else if (press[0] && !press[1]) sel_d = (sel_q == COUNT_ONES) ? RESET : opr_mode_t'(sel_q + 3'd1);
    else if (press[1] && !press[0]) sel_d = (sel_q == RESET) ? COUNT_ONES : opr_mode_t'(sel_q - 3'd1);
    sw_d = (|press) ? SW : sw_q;
  end
  // mode, operand snapshot and change strobe registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q <= RESET;
      sw_q  <= '0;
      chg_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      sw_q  <= sw_d;
      chg_q <= sel_d != sel_q;
    end
  end
  assign SELECTOR     = sel_q;
  assign SW_Q         = sw_q;
  assign mode_changed = chg_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: table-driven and directed checks of the button-driven mode sequencer
module tb_mode_sequencer;
  localparam int D = 4;
  localparam int S = 2;
  logic       clk = 0, rst_n = 0, BTNU = 0, BTND = 0, BTNC = 0;
  logic [7:0] SW = 0;
  logic [2:0] SELECTOR;
  logic [7:0] SW_Q;
  logic       mode_changed;
  int checks = 0, errors = 0, pulses = 0;
  typedef struct {
    logic [2:0] m;
    logic [7:0] sw;
    logic [2:0] sel;
    logic [7:0] swq;
    int         np;
  } vec_t;
  vec_t v[18];
  always #5 clk = ~clk;
  mode_sequencer #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .BTNU(BTNU), .BTND(BTND), .BTNC(BTNC), .SW(SW),
    .SELECTOR(SELECTOR), .SW_Q(SW_Q), .mode_changed(mode_changed)
  );
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (mode_changed === 1'b1) pulses++;
    end
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic set_btn(input logic [2:0] m);
    {BTNC, BTND, BTNU} = m;
  endtask
  initial begin
    int p0, n;
    logic [6:0] pat;
    // mask bits are {C,D,U}; modes RESET=0 ADD=1 SUB=2 MUL=3 LEADING_ONES=4 COUNT_ONES=5
    v[0]  = '{3'b001, 8'h01, 3'd1, 8'h01, 1};
    v[1]  = '{3'b001, 8'h02, 3'd2, 8'h02, 1};
    v[2]  = '{3'b001, 8'h03, 3'd3, 8'h03, 1};
    v[3]  = '{3'b001, 8'h04, 3'd4, 8'h04, 1};
    v[4]  = '{3'b001, 8'h05, 3'd5, 8'h05, 1};
    v[5]  = '{3'b001, 8'h06, 3'd0, 8'h06, 1};
    v[6]  = '{3'b010, 8'h5A, 3'd5, 8'h5A, 1};
    v[7]  = '{3'b000, 8'hFF, 3'd5, 8'h5A, 0};
    v[8]  = '{3'b010, 8'h11, 3'd4, 8'h11, 1};
    v[9]  = '{3'b001, 8'h12, 3'd5, 8'h12, 1};
    v[10] = '{3'b100, 8'h13, 3'd0, 8'h13, 1};
    v[11] = '{3'b100, 8'h14, 3'd0, 8'h14, 0};
    v[12] = '{3'b001, 8'h21, 3'd1, 8'h21, 1};
    v[13] = '{3'b001, 8'h22, 3'd2, 8'h22, 1};
    v[14] = '{3'b011, 8'h33, 3'd2, 8'h33, 0};
    v[15] = '{3'b001, 8'h44, 3'd3, 8'h44, 1};
    v[16] = '{3'b101, 8'h55, 3'd0, 8'h55, 1};
    v[17] = '{3'b111, 8'h66, 3'd0, 8'h66, 0};
    SW = 8'hFF;
    BTNU = 1;
    rst_n = 0;
    tick(3);
    chk("rst_sel", SELECTOR, 0);
    chk("rst_swq", SW_Q, 0);
    chk("rst_mc", mode_changed, 0);
    rst_n = 1;
    p0 = pulses;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (SELECTOR == 3'd1) begin
        n = i;
        break;
      end
    end
    chk("rst_release_latency", n, D + S + 2);
    chk("rst_release_swq", SW_Q, 8'hFF);
    BTNU = 0;
    tick(8);
    chk("rst_release_pulses", pulses - p0, 1);
    SW = 0;
    rst_n = 0;
    tick(2);
    rst_n = 1;
    chk("rst2_sel", SELECTOR, 0);
    for (int i = 0; i < 18; i++) begin
      SW = v[i].sw;
      set_btn(v[i].m);
      p0 = pulses;
      tick(8);
      set_btn(3'b000);
      tick(8);
      chk($sformatf("vec%0d_sel", i), SELECTOR, v[i].sel);
      chk($sformatf("vec%0d_swq", i), SW_Q, v[i].swq);
      chk($sformatf("vec%0d_pulses", i), pulses - p0, v[i].np);
    end
    SW = 8'h99;
    p0 = pulses;
    BTNU = 1;
    tick(3);
    BTNU = 0;
    tick(13);
    chk("glitch_sel", SELECTOR, 0);
    chk("glitch_pulses", pulses - p0, 0);
    chk("glitch_swq", SW_Q, 8'h66);
    pat = 7'b1011111;
    p0 = pulses;
    for (int i = 6; i >= 0; i--) begin
      BTNU = pat[i];
      tick();
    end
    BTNU = 0;
    tick(12);
    chk("bounce_sel", SELECTOR, 1);
    chk("bounce_pulses", pulses - p0, 1);
    SW = 8'h77;
    p0 = pulses;
    BTNU = 1;
    tick(50);
    chk("hold_sel", SELECTOR, 2);
    chk("hold_pulses", pulses - p0, 1);
    rst_n = 0;
    tick();
    chk("midrst_sel", SELECTOR, 0);
    chk("midrst_swq", SW_Q, 0);
    chk("midrst_mc", mode_changed, 0);
    rst_n = 1;
    p0 = pulses;
    tick(50);
    chk("posthold_sel", SELECTOR, 1);
    chk("posthold_pulses", pulses - p0, 1);
    chk("posthold_swq", SW_Q, 8'h77);
    BTNU = 0;
    tick(20);
    chk("release_sel", SELECTOR, 1);
    chk("release_pulses", pulses - p0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
